ifid_stage: RTL
===============

Name: ifid_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection and branch flush. It sits directly upstream of IDEX.
- Captures the fetched instruction and pc4 each cycle, and splits out rs/rt/rd/immediate for register-file read and the IDEX inputs.
- Drives pc_write to the PC and ctrl_bubble to the control mux in front of IDEX.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- NOP_WORD, 32'h0000_0000, instruction word inserted on flush (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc4  in  32  PC+4 from the IF stage.
- instr  in  32  instruction word from instruction memory.
- idex_MemRead  in  1  MemRead currently held in IDEX (mem_MemRead_out).
- idex_rt  in  5  rt currently held in IDEX (rt_out).
- branch_taken  in  1  branch resolved taken in EX (ex_branch_out AND ALU zero).
- pc4_out  out  32  registered pc4.
- instr_out  out  32  registered instruction.
- valid_out  out  1  instr_out holds a real fetched instruction.
- opcode_out  out  6  instr_out[31:26].
- rs_out  out  5  instr_out[25:21].
- rt_out  out  5  instr_out[20:16].
- rd_out  out  5  instr_out[15:11].
- immediate_out  out  16  instr_out[15:0].
- pc_write  out  1  PC may update this cycle.
- ctrl_bubble  out  1  zero all control bits entering IDEX this cycle.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of branch flushes.

Behaviour:
- Reset (reset==0, asynchronous):
  - instr_out=NOP_WORD, pc4_out=0, valid_out=0, stall_count=0, flush_count=0.
  - Decoded fields follow instr_out, so all are 0.
  - Held until the first rising clk after reset deasserts.
- Combinational outputs:
  - uses_rt = opcode_out==6'h00 (R-type) | 6'h04 (beq) | 6'h2B (sw).
  - load_use = valid_out & idex_MemRead & (idex_rt!=0) & ((idex_rt==rs_out) | (uses_rt & idex_rt==rt_out)).
  - pc_write = ~load_use | branch_taken.
  - ctrl_bubble = load_use | branch_taken.
  - During reset: pc_write=1, ctrl_bubble=0, because valid_out=0 and branch_taken is ignored while reset is asserted.
- Posedge clk, priority order:
  1. branch_taken: instr_out<=NOP_WORD, valid_out<=0, pc4_out<=pc4, flush_count++ (saturating). Branch takes priority over a simultaneous load_use.
  2. else load_use: hold instr_out, pc4_out and valid_out; stall_count++ (saturating).
  3. else: instr_out<=instr, pc4_out<=pc4, valid_out<=1.
- Latency: one cycle from instr to instr_out.
- Stall length: a load-use stall lasts exactly one cycle. The bubble clears idex_MemRead on the next edge, so load_use drops.
- Counters: saturate at all-ones and never wrap. Both update independently of each other.
- Reset mid-stall or mid-flush: asynchronous clear wins immediately; no partial state survives.
- $zero destination (idex_rt==0) never stalls.
- A flushed slot (valid_out=0) never raises load_use.

Decomposition:
- Shared include pipe_defs.vh holds:
  - opcode constants: OP_RTYPE 6'h00, OP_BEQ 6'h04, OP_LW 6'h23, OP_SW 6'h2B;
  - NOP_WORD.
- Sub-module hazard_detect: purely combinational. Inputs: valid, opcode, rs, rt, idex_MemRead, idex_rt, branch_taken. Outputs: load_use, pc_write, ctrl_bubble.
- ifid_stage instantiates hazard_detect and holds the registers and counters.

Test Plan:
- Reset check: hold reset=0 for 3 clk with instr=32'h8C220004 → instr_out=0, valid_out=0, pc_write=1, ctrl_bubble=0, both counters 0.
- Normal flow: release reset; instr=32'h00221820 (add $3,$1,$2), pc4=4 → after 1 clk: instr_out=32'h00221820, rs_out=1, rt_out=2, rd_out=3, valid_out=1.
- Load-use stall: IF/ID holds add $3,$1,$2; idex_MemRead=1, idex_rt=2 → load_use=1, pc_write=0, ctrl_bubble=1. Next edge: instr_out unchanged, stall_count=1. Drop idex_MemRead → next edge loads the new instr.
- No false stall:
  - idex_rt=0 with MemRead=1 → no stall.
  - IF/ID holds lw $5,0($1) (rt not used as source), idex_rt=5, MemRead=1 → no stall.
- Branch flush with simultaneous hazard: branch_taken=1 and load_use=1 in the same cycle → pc_write=1, ctrl_bubble=1. Next edge: instr_out=NOP_WORD, valid_out=0, flush_count=1, stall_count unchanged.
- Saturation and async reset: run with CNT_W=2 and 5 flushes → flush_count=3. Assert reset mid-cycle (between edges) → all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifid_stage_pkg.sv
// rtl/ifid_stage_pkg.sv - opcode constants and NOP word shared by the IF/ID stage
package ifid_stage_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Opcodes that read rt as a source operand; lw writes rt instead.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/ifid_stage_hazard_detect.sv
// rtl/ifid_stage_hazard_detect.sv - combinational load-use hazard and branch flush control
module hazard_detect
  import ifid_stage_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       idex_MemRead,
  input  logic [4:0] idex_rt,
  input  logic       branch_taken,
  output logic       load_use,
  output logic       pc_write,
  output logic       ctrl_bubble
);

  logic rt_hit;
  logic rs_hit;

  assign rs_hit = (idex_rt == rs);
  assign rt_hit = uses_rt(opcode) && (idex_rt == rt);

  // A load into $zero produces no real dependency.
  assign load_use    = valid && idex_MemRead && (idex_rt != 5'd0) && (rs_hit || rt_hit);
  assign pc_write    = !load_use || branch_taken;
  assign ctrl_bubble = load_use || branch_taken;

endmodule

// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - IF/ID pipeline register with hazard stall, branch flush and perf counters
module ifid_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = ifid_stage_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc4,
  input  logic [31:0]      instr,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  output logic [31:0]      pc4_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic [5:0]       opcode_out,
  output logic [4:0]       rs_out,
  output logic [4:0]       rt_out,
  output logic [4:0]       rd_out,
  output logic [15:0]      immediate_out,
  output logic             pc_write,
  output logic             ctrl_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic load_use;
  logic branch_eff;

  // Branch resolution is meaningless while the pipeline is held in reset.
  assign branch_eff = branch_taken && reset;

  assign opcode_out    = instr_out[31:26];
  assign rs_out        = instr_out[25:21];
  assign rt_out        = instr_out[20:16];
  assign rd_out        = instr_out[15:11];
  assign immediate_out = instr_out[15:0];

  hazard_detect u_hazard (
    .valid        (valid_out),
    .opcode       (opcode_out),
    .rs           (rs_out),
    .rt           (rt_out),
    .idex_MemRead (idex_MemRead),
    .idex_rt      (idex_rt),
    .branch_taken (branch_eff),
    .load_use     (load_use),
    .pc_write     (pc_write),
    .ctrl_bubble  (ctrl_bubble)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_out   <= NOP_WORD;
      pc4_out     <= 32'd0;
      valid_out   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (branch_eff) begin
      instr_out <= NOP_WORD;
      pc4_out   <= pc4;
      valid_out <= 1'b0;
      if (flush_count != '1) flush_count <= flush_count + 1'b1;
    end else if (load_use) begin
      if (stall_count != '1) stall_count <= stall_count + 1'b1;
    end else begin
      instr_out <= instr;
      pc4_out   <= pc4;
      valid_out <= 1'b1;
    end
  end

endmodule
